line_option_gen: RTL and testbench

//  Enumerates every legal placement ("option") of one nonogram line's clue blocks and streams them to
//  the option FIFO that feeds the solver. Per line: one header word (line index), then one bitmask word
//  per option. Reports the option count for the solver's options-amount table. Runs once per line after

---
 rtl/nonogram_pkg.sv | 29 ++
 rtl/placement_next.sv | 38 +++
 rtl/line_option_gen.sv | 135 +++++++++++++
 tb/tb_line_option_gen.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nonogram_pkg.sv
// nonogram_pkg: shared board limits, line/option types and FIFO word layout.
package nonogram_pkg;
  localparam int MAX_ROWS    = 11;
  localparam int MAX_COLS    = 11;
  localparam int MAX_BLOCKS  = 6;
  localparam int MAX_OPTIONS = 462;
  localparam int DATA_W      = 16;
  localparam int LEN_W       = 4;
  localparam int NB_W        = 3;
  localparam int CNT_W       = $clog2(MAX_OPTIONS + 1);
  localparam int IDX_W       = $clog2(MAX_ROWS + MAX_COLS);
  typedef logic [LEN_W-1:0] pos_t;
  typedef logic [LEN_W-1:0] len_t;
  typedef pos_t [MAX_BLOCKS-1:0] pos_vec_t;
  typedef len_t [MAX_BLOCKS-1:0] len_vec_t;
  typedef logic [NB_W-1:0] nb_t;
  typedef logic [DATA_W-1:0] fifo_word_t;
  function automatic fifo_word_t header_word(logic [IDX_W-1:0] idx);
    return fifo_word_t'(idx);
  endfunction
  // Option word: bit i set when cell i is covered by some block; cells past the line end stay 0.
  function automatic fifo_word_t line_mask(pos_vec_t pos, len_vec_t lens, nb_t nb, len_t line_len);
    fifo_word_t m;
    m = '0;
    for (int k = 0; k < MAX_BLOCKS; k++)
      if (k < int'(nb)) m = m | (fifo_word_t'((fifo_word_t'(1) << lens[k]) - 1'b1) << pos[k]);
    return m & fifo_word_t'((fifo_word_t'(1) << line_len) - 1'b1);
  endfunction
endpackage

// File: rtl/placement_next.sv
// placement_next: lexicographic successor of a block placement and the mask of the current one.
module placement_next
  import nonogram_pkg::*;
(
  input  pos_vec_t   pos,
  input  len_vec_t   lens,
  input  nb_t        nb,
  input  len_t       line_len,
  output pos_vec_t   next_pos,
  output logic       has_next,
  output fifo_word_t mask
);
  pos_vec_t right;
  logic [LEN_W:0] end_p, lim;
  pos_t run;
  int kk;
  assign right = {pos_t'(0), pos[MAX_BLOCKS-1:1]};
  assign mask = line_mask(pos, lens, nb, line_len);
  always_comb begin
    has_next = 1'b0;
    kk = 0;
    end_p = '0;
    lim = '0;
    run = '0;
    for (int k = 0; k < MAX_BLOCKS; k++) begin
      end_p = {1'b0, pos[k]} + {1'b0, lens[k]};
      lim = (k + 1 < int'(nb)) ? {1'b0, right[k]} - 1'b1 : {1'b0, line_len};
      if (k < int'(nb) && end_p < lim) begin
        has_next = 1'b1;
        kk = k;
      end
    end
    for (int j = 0; j < MAX_BLOCKS; j++) begin
      next_pos[j] = (j < kk) ? pos[j] : (j == kk) ? pos[j] + 1'b1 : run;
      run = next_pos[j] + lens[j] + 1'b1;
    end
  end
endmodule

// File: rtl/line_option_gen.sv
// line_option_gen: streams a header word then every legal block placement mask of one nonogram line.
module line_option_gen
  import nonogram_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [IDX_W-1:0] line_index,
  input  len_t             line_len,
  input  nb_t              num_blocks,
  input  len_vec_t         clue_lens,
  output logic             busy,
  output logic             out_valid,
  output fifo_word_t       out_data,
  input  logic             out_ready,
  output logic             done,
  output logic [CNT_W-1:0] opt_count,
  output logic             infeasible
);
  typedef enum logic [2:0] {IDLE, CHECK, HEADER, EMIT, FIN} state_t;
  state_t state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  len_t len_q, len_d;
  nb_t nb_q, nb_d;
  len_vec_t lens_q, lens_d;
  pos_vec_t pos_q, pos_d, pack, next_pos;
  logic busy_q, busy_d, valid_q, valid_d, done_q, done_d, inf_q, inf_d, has_next;
  fifo_word_t data_q, data_d, mask;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0] need_p1;
  pos_t run;
  placement_next u_next (
    .pos(pos_q), .lens(lens_q), .nb(nb_q), .line_len(len_q),
    .next_pos(next_pos), .has_next(has_next), .mask(mask)
  );
  // need_p1 is the packed width plus one, so an empty clue list never looks infeasible.
  always_comb begin
    need_p1 = '0;
    run = '0;
    for (int k = 0; k < MAX_BLOCKS; k++) begin
      pack[k] = run;
      run = run + lens_q[k] + 1'b1;
      if (k < int'(nb_q)) need_p1 = need_p1 + 8'(lens_q[k]) + 8'd1;
    end
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    len_d = len_q;
    nb_d = nb_q;
    lens_d = lens_q;
    pos_d = pos_q;
    busy_d = busy_q;
    valid_d = valid_q;
    data_d = data_q;
    done_d = 1'b0;
    inf_d = inf_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = CHECK;
        idx_d = line_index;
        len_d = line_len;
        nb_d = num_blocks;
        lens_d = clue_lens;
        busy_d = 1'b1;
        inf_d = 1'b0;
        cnt_d = '0;
      end
      CHECK: if (need_p1 > 8'(len_q) + 8'd1) begin
        state_d = FIN;
        inf_d = 1'b1;
        done_d = 1'b1;
        busy_d = 1'b0;
      end else begin
        state_d = HEADER;
        pos_d = pack;
        valid_d = 1'b1;
        data_d = header_word(idx_q);
      end
      HEADER: if (out_ready) begin
        state_d = EMIT;
        data_d = mask;
      end
      EMIT: if (out_ready) begin
        cnt_d = (cnt_q == CNT_W'(MAX_OPTIONS)) ? cnt_q : cnt_q + 1'b1;
        if (has_next) begin
          pos_d = next_pos;
          data_d = line_mask(next_pos, lens_q, nb_q, len_q);
        end else begin
          state_d = FIN;
          valid_d = 1'b0;
          done_d = 1'b1;
          busy_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q <= '0;
      len_q <= '0;
      nb_q <= '0;
      lens_q <= '0;
      pos_q <= '0;
      busy_q <= 1'b0;
      valid_q <= 1'b0;
      data_q <= '0;
      done_q <= 1'b0;
      inf_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      len_q <= len_d;
      nb_q <= nb_d;
      lens_q <= lens_d;
      pos_q <= pos_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      data_q <= data_d;
      done_q <= done_d;
      inf_q <= inf_d;
      cnt_q <= cnt_d;
    end
  end
  assign busy = busy_q;
  assign out_valid = valid_q;
  assign out_data = data_q;
  assign done = done_q;
  assign opt_count = cnt_q;
  assign infeasible = inf_q;
endmodule

// File: tb/tb_line_option_gen.sv
// tb_line_option_gen: directed and random lines checked against a brute-force enumeration of all masks.
module tb_line_option_gen;
  import nonogram_pkg::*;
  logic clk = 1'b0, rst, start, out_ready;
  logic [IDX_W-1:0] line_index;
  len_t line_len;
  nb_t num_blocks;
  len_vec_t clue_lens;
  logic busy, out_valid, done, infeasible;
  fifo_word_t out_data;
  logic [CNT_W-1:0] opt_count;
  int n_assert = 0, n_fail = 0;
  int exp_q[$];
  line_option_gen dut (
    .clk(clk), .rst(rst), .start(start), .line_index(line_index), .line_len(line_len),
    .num_blocks(num_blocks), .clue_lens(clue_lens), .busy(busy), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .done(done), .opt_count(opt_count),
    .infeasible(infeasible)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask
  // Every mask whose runs of ones equal the clues, ordered by block start positions (leftmost most significant).
  task automatic build_model(input int len, input int nb, input len_vec_t cl);
    int keys[$];
    int runs[16];
    int starts[16];
    int nr, key, idx;
    bit in_run, ok;
    exp_q.delete();
    for (int m = 0; m < (1 << len); m++) begin
      nr = 0;
      in_run = 0;
      for (int i = 0; i < len; i++) begin
        if (((m >> i) & 1) == 1) begin
          if (!in_run) begin
            starts[nr] = i;
            runs[nr] = 0;
            nr++;
          end
          runs[nr-1]++;
          in_run = 1;
        end else in_run = 0;
      end
      ok = (nr == nb);
      for (int k = 0; k < nr; k++) if (ok && runs[k] != int'(cl[k])) ok = 0;
      if (ok) begin
        key = 0;
        for (int k = 0; k < nb; k++) key = key * 16 + starts[k];
        idx = 0;
        while (idx < keys.size() && keys[idx] < key) idx++;
        keys.insert(idx, key);
        exp_q.insert(idx, m);
      end
    end
  endtask
  // mode 0: ready always high, 1: random ready, 2: hold ready low 3 cycles while the 2nd option is shown
  task automatic run_line(input int idx, input int len, input int nb, input len_vec_t cl,
                          input int mode, input bit glitch);
    int got_q[$];
    int stall, cyc;
    bit finished, gl_done, inf_exp;
    build_model(len, nb, cl);
    inf_exp = (exp_q.size() == 0);
    @(negedge clk);
    line_index = IDX_W'(idx);
    line_len = len_t'(len);
    num_blocks = nb_t'(nb);
    clue_lens = cl;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    stall = 0;
    cyc = 0;
    finished = 0;
    gl_done = 0;
    while (!finished && cyc < 3000) begin
      out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ($urandom_range(0, 3) != 0) : (stall == 0);
      if (glitch && !gl_done && got_q.size() == 1) begin
        start = 1'b1;
        line_len = len_t'(11);
        gl_done = 1;
      end else start = 1'b0;
      if (stall > 0) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, exp_q[1]);
        stall--;
      end
      if (done) begin
        finished = 1;
        chk("done_busy", busy, 0);
        chk("done_valid", out_valid, 0);
        chk("opt_count", opt_count, exp_q.size());
        chk("infeasible", infeasible, inf_exp);
        @(negedge clk);
        chk("done_one_pulse", done, 0);
        chk("opt_count_held", opt_count, exp_q.size());
      end else begin
        if (out_valid && out_ready) begin
          got_q.push_back(int'(out_data));
          if (mode == 2 && got_q.size() == 2) stall = 3;
        end
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk("line_finished", finished, 1);
    chk("word_count", got_q.size(), inf_exp ? 0 : exp_q.size() + 1);
    if (!inf_exp && got_q.size() > 0) chk("header", got_q[0], idx);
    for (int i = 0; i < exp_q.size() && i + 1 < got_q.size(); i++) chk("option", got_q[i+1], exp_q[i]);
  endtask
  len_vec_t cl;
  int len, nb, mx;
  initial begin
    rst = 1'b1;
    start = 1'b0;
    out_ready = 1'b1;
    line_index = '0;
    line_len = '0;
    num_blocks = '0;
    clue_lens = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_inf", infeasible, 0);
    chk("rst_data", out_data, 0);
    chk("rst_count", opt_count, 0);
    rst = 1'b0;
    cl = '0; cl[0] = 4'd2; cl[1] = 4'd1;
    run_line(3, 5, 2, cl, 0, 0);
    chk("ex21_opt0", exp_q[0], 32'h00B);
    cl = '0; cl[0] = 4'd11;
    run_line(21, 11, 1, cl, 0, 0);
    cl = '0;
    run_line(7, 4, 0, cl, 0, 0);
    cl = '0; cl[0] = 4'd3; cl[1] = 4'd3;
    run_line(12, 6, 2, cl, 0, 0);
    cl = '0; cl[0] = 4'd1;
    run_line(5, 5, 1, cl, 2, 0);
    // abandon a line mid-stream with reset
    cl = '0; cl[0] = 4'd1;
    @(negedge clk);
    line_len = len_t'(11); num_blocks = nb_t'(1); clue_lens = cl; line_index = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_valid", out_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_count", opt_count, 0);
    run_line(2, 3, 1, cl, 0, 1);
    for (int t = 0; t < 40; t++) begin
      len = $urandom_range(1, 11);
      mx = (len < MAX_BLOCKS) ? len : MAX_BLOCKS;
      nb = $urandom_range(0, mx);
      for (int k = 0; k < MAX_BLOCKS; k++)
        cl[k] = (k < nb) ? len_t'($urandom_range(1, (nb > 0 ? len / nb : 1) + 1)) : len_t'($urandom_range(0, 15));
      run_line($urandom_range(0, 21), len, nb, cl, 1, 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
